// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA stream writer.
// AXI3 encodings, FSM states and beat-size helper.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [2:0] awsize_of(input int unsigned data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/dma_stream_writer_if.sv
// AXI3 write-only channel bundle (AW, W, B).
// Master drives addresses/data, slave returns ready and response.
interface dma_stream_writer_if #(
    parameter int DATA_W = 64
);

    logic [31:0]         awaddr;
    logic                awvalid;
    logic                awready;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic                wlast;
    logic                bvalid;
    logic [1:0]          bresp;
    logic                bready;

    modport master (
        output awaddr, awvalid, awlen, awsize, awburst,
        output wdata, wstrb, wvalid, wlast, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awaddr, awvalid, awlen, awsize, awburst,
        input  wdata, wstrb, wvalid, wlast, bready,
        output awready, wready, bvalid, bresp
    );

endinterface

// File: rtl/posedge_detector.sv
// Rising-edge detector for a level input.
// The previous level is registered; the pulse lasts one cycle.
module posedge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic level_q;

    // Remember last cycle's level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy count.
// A full FIFO still accepts a push when a pop frees a slot.
module sync_fifo #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and count; flush discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_stream_writer.sv
// Streams samples into a DDR window as fixed-length AXI3 bursts.
// One-shot or ring capture, bounded retry on error, abort, counters.
module dma_stream_writer #(
    parameter int          DATA_W     = 64,
    parameter int          BURST_LEN  = 16,
    parameter int          FIFO_DEPTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter logic [31:0] BUF_BYTES  = 32'h000C_3500,
    parameter int          MAX_RETRY  = 3
) (
    input  logic              aclk,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    dma_stream_writer_if.master m_axi,
    output logic              busy_o,
    output logic              done_o,
    output logic              wrap_o,
    output logic              err_o,
    output logic              overflow_o,
    output logic [31:0]       burst_cnt_o
);

    import dma_pkg::*;

    localparam int          BEAT_BYTES  = DATA_W / 8;
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * BEAT_BYTES);
    localparam logic [31:0] END_ADDR    = BASE_ADDR + BUF_BYTES;
    localparam int          CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FILL_LEVEL = CNT_W'(BURST_LEN);
    localparam logic [3:0]  LAST_BEAT   = 4'(BURST_LEN - 1);
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRY);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("DATA_W must be 32 or 64");
    end
    if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_burst
        $error("BURST_LEN must be 1..16");
    end
    if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        FIFO_DEPTH < BURST_LEN) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 >= BURST_LEN");
    end
    if (BASE_ADDR % BURST_BYTES != 0) begin : g_bad_base
        $error("BASE_ADDR must be burst aligned");
    end
    if (BUF_BYTES == 0 ||
        BUF_BYTES % BURST_BYTES != 0) begin : g_bad_buf
        $error("BUF_BYTES must be a multiple of the burst size");
    end
    if (MAX_RETRY < 1) begin : g_bad_retry
        $error("MAX_RETRY must be at least 1");
    end

    state_t            state;
    state_t            state_d;
    logic [31:0]       addr;
    logic [31:0]       addr_d;
    logic [31:0]       cnt;
    logic [31:0]       cnt_d;
    logic [3:0]        beat;
    logic [3:0]        beat_d;
    logic [7:0]        retry;
    logic [7:0]        retry_d;
    logic              err;
    logic              err_d;
    logic              ovf;
    logic              ovf_d;
    logic              wrap;
    logic              wrap_d;
    logic              mode;
    logic              mode_d;
    logic              abort_pend;
    logic              abort_d;
    logic              flush;
    logic              start_edge;
    logic              busy;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_rdata;
    logic [31:0]       next_addr;

    posedge_detector u_start_edge (
        .clk   (aclk),
        .rst_n (rst_ni),
        .level (start_i),
        .pulse (start_edge)
    );

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (aclk),
        .rst_n (rst_ni),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (s_data_i),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full)
    );

    assign busy      = (state == ST_FILL) || (state == ST_ADDR) ||
                       (state == ST_DATA) || (state == ST_RESP);
    assign pop       = (state == ST_DATA) && m_axi.wready;
    assign s_ready_o = busy && (!fifo_full || pop);
    assign push      = s_valid_i && s_ready_o;
    assign next_addr = addr + BURST_BYTES;

    // Next-state and bookkeeping for the capture sequencer.
    always_comb begin
        state_d = state;
        addr_d  = addr;
        cnt_d   = cnt;
        beat_d  = beat;
        retry_d = retry;
        err_d   = err;
        ovf_d   = ovf;
        wrap_d  = 1'b0;
        mode_d  = mode;
        abort_d = abort_pend;
        flush   = 1'b0;
        if (busy && abort_i) begin
            abort_d = 1'b1;
        end
        if (busy && s_valid_i && !s_ready_o) begin
            ovf_d = 1'b1;
        end
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_edge) begin
                    state_d = ST_FILL;
                    flush   = 1'b1;
                    addr_d  = BASE_ADDR;
                    cnt_d   = '0;
                    beat_d  = '0;
                    retry_d = '0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                    mode_d  = mode_i;
                    abort_d = 1'b0;
                end
            end
            ST_FILL: begin
                if (abort_i || abort_pend) begin
                    state_d = ST_IDLE;
                    flush   = 1'b1;
                    abort_d = 1'b0;
                end else if (fifo_count >= FILL_LEVEL) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_axi.awready) begin
                    state_d = ST_DATA;
                    beat_d  = '0;
                end
            end
            ST_DATA: begin
                if (m_axi.wready) begin
                    beat_d = beat + 4'd1;
                    if (beat == LAST_BEAT) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (m_axi.bvalid) begin
                    if (m_axi.bresp == AXI_RESP_OKAY) begin
                        retry_d = '0;
                        cnt_d   = cnt + 32'd1;
                        if (next_addr >= END_ADDR) begin
                            if (mode) begin
                                addr_d  = BASE_ADDR;
                                wrap_d  = 1'b1;
                                state_d = ST_FILL;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            addr_d  = next_addr;
                            state_d = ST_FILL;
                        end
                    end else begin
                        err_d   = 1'b1;
                        retry_d = retry + 8'd1;
                        if (retry + 8'd1 >= RETRY_LIMIT) begin
                            state_d = ST_ERROR;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and status registers.
    always_ff @(posedge aclk or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_IDLE;
            addr       <= BASE_ADDR;
            cnt        <= '0;
            beat       <= '0;
            retry      <= '0;
            err        <= 1'b0;
            ovf        <= 1'b0;
            wrap       <= 1'b0;
            mode       <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            state      <= state_d;
            addr       <= addr_d;
            cnt        <= cnt_d;
            beat       <= beat_d;
            retry      <= retry_d;
            err        <= err_d;
            ovf        <= ovf_d;
            wrap       <= wrap_d;
            mode       <= mode_d;
            abort_pend <= abort_d;
        end
    end

    assign m_axi.awaddr  = addr;
    assign m_axi.awvalid = (state == ST_ADDR);
    assign m_axi.awlen   = LAST_BEAT;
    assign m_axi.awsize  = awsize_of(DATA_W);
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.wdata   = fifo_rdata;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = (state == ST_DATA);
    assign m_axi.wlast   = (state == ST_DATA) && (beat == LAST_BEAT);
    assign m_axi.bready  = (state == ST_RESP);

    assign busy_o      = busy;
    assign done_o      = (state == ST_DONE);
    assign wrap_o      = wrap;
    assign err_o       = err;
    assign overflow_o  = ovf;
    assign burst_cnt_o = cnt;

endmodule
